// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch sequencer for a 256 x 32 asynchronous-read program
// memory. It owns the program counter and drives the memory address. Each
// returned word is registered into a one-entry fetch slot that is offered to
// decode. Taken branches and jumps redirect the pc, and fetching stops on the
// halt opcode 7'b1111111.
// Optional build macro: FETCH_PERF_CNT_EN adds the fetch_cnt and stall_cnt
// performance counters.
//
// Handshake: decode takes the slot at a rising edge when if_valid and
// if_ready are both high in the cycle before that edge. if_instr and if_pc
// hold steady while if_valid=1 and if_ready=0. A redirect drops the slot
// without an accept, even if if_ready=1.
module instr_fetch_ctrl #(
  parameter int ADD_WIDTH = 8,
  parameter int WIDTH     = 32,
  parameter logic [ADD_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [ADD_WIDTH-1:0] mem_add,
  input  logic [WIDTH-1:0]     mem_instr,
  output logic                 if_valid,
  output logic [WIDTH-1:0]     if_instr,
  output logic [ADD_WIDTH-1:0] if_pc,
  input  logic                 if_ready,
  input  logic                 redirect_valid,
  input  logic [ADD_WIDTH-1:0] redirect_pc,
  output logic                 busy,
  output logic                 halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]          fetch_cnt,
  output logic [15:0]          stall_cnt,
`endif
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    HALT_PEND = 2'd2,
    HALT      = 2'd3
  } state_t;

  localparam logic [ADD_WIDTH-1:0] PC_ONE   = 1;
  localparam logic [6:0]           HALT_OPC = 7'b1111111;

  state_t               state;
  logic [ADD_WIDTH-1:0] pc;
  logic                 slot_free;
  logic                 is_halt;
  logic                 fetch;

  assign mem_add   = pc;
  assign fsm_state = state;

  // Fetch decision: the slot can be reloaded when it is empty or is being
  // accepted this cycle. A redirect always wins over a fetch.
  always_comb begin
    slot_free = !if_valid || if_ready;
    is_halt   = (mem_instr[6:0] == HALT_OPC);
    fetch     = (state == RUN) && !redirect_valid && slot_free;
  end

  // Sequencer FSM: pc, fetch slot, and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            pc    <= RESET_PC;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (redirect_valid) begin
            pc       <= redirect_pc;
            if_valid <= 1'b0;
          end else if (fetch) begin
            if_instr <= mem_instr;
            if_pc    <= pc;
            if_valid <= 1'b1;
            // The pc stays on the halt word so that mem_add parks there.
            if (is_halt) state <= HALT_PEND;
            else         pc    <= pc + PC_ONE;
          end
        end
        HALT_PEND: begin
          if (redirect_valid) begin
            pc       <= redirect_pc;
            if_valid <= 1'b0;
            state    <= RUN;
          end else if (if_valid && if_ready) begin
            if_valid <= 1'b0;
            state    <= HALT;
            busy     <= 1'b0;
            halted   <= 1'b1;
          end
        end
        HALT: begin
          if (start) begin
            state  <= RUN;
            pc     <= RESET_PC;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic start_accept;
  assign start_accept = start && ((state == IDLE) || (state == HALT));

  // Saturating performance counters. They clear when a new run starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (start_accept) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch && (fetch_cnt != 16'hFFFF))
        fetch_cnt <= fetch_cnt + 16'd1;
      if (if_valid && !if_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Testbench for instr_fetch_ctrl. The program memory is modelled as an array
// with a combinational read. A negedge monitor pops the expected
// {pc, instr} pair for every accepted slot.
module tb_instr_fetch_ctrl;
  localparam int AW = 8;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] mem_add;
  logic [W-1:0]  mem_instr;
  logic          if_valid;
  logic [W-1:0]  if_instr;
  logic [AW-1:0] if_pc;
  logic          if_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          busy;
  logic          halted;
  logic [1:0]    fsm_state;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]   fetch_cnt;
  logic [15:0]   stall_cnt;
`endif

  logic [W-1:0]    prog [256];
  logic [AW+W-1:0] exp_q [$];
  int tests_run = 0;
  int tests_failed = 0;

  instr_fetch_ctrl #(.ADD_WIDTH(AW), .WIDTH(W), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_add(mem_add),
    .mem_instr(mem_instr), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_ready(if_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy), .halted(halted),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
    .fsm_state(fsm_state)
  );

  assign mem_instr = prog[mem_add];

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: compare every accepted slot against the expected queue
  always @(negedge clk) begin
    logic [AW+W-1:0] e;
    if (rst_n && if_valid && if_ready && !redirect_valid) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL accept_unexpected: got pc=%0h instr=%0h, queue empty", if_pc, if_instr);
      end else begin
        e = exp_q.pop_front();
        if ({if_pc, if_instr} !== e) begin
          tests_failed++;
          $display("FAIL accept_order: got pc=%0h instr=%0h, expected pc=%0h instr=%0h",
                   if_pc, if_instr, e[AW+W-1:W], e[W-1:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int first, input int count);
    logic [AW-1:0] a;
    for (int i = 0; i < count; i++) begin
      a = AW'(first + i);
      exp_q.push_back({a, prog[a]});
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    tests_run++;
    if ({if_valid, busy, halted} !== 3'b000 || mem_add !== 8'h00 ||
        if_instr !== 32'h0 || if_pc !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_values: got v=%0b b=%0b h=%0b add=%0h instr=%0h pc=%0h, expected all 0",
               if_valid, busy, halted, mem_add, if_instr, if_pc);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({if_valid, busy, halted} !== 3'b000 || mem_add !== 8'h00) begin
      tests_failed++;
      $display("FAIL idle_no_fetch: got v=%0b b=%0b h=%0b add=%0h, expected 0 0 0 0",
               if_valid, busy, halted, mem_add);
    end
  endtask

  task automatic test_run_to_halt;
    int n = 0;
    if_ready = 1'b1;
    push_range(0, 10);
    pulse_start();
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    tests_run++;
    if (n !== 11) begin
      tests_failed++;
      $display("FAIL run_throughput: got %0d cycles to drain, expected 11", n);
    end
    tests_run++;
    if (halted !== 1'b1 || busy !== 1'b0 || if_valid !== 1'b0 || mem_add !== 8'h09) begin
      tests_failed++;
      $display("FAIL run_halted: got h=%0b b=%0b v=%0b add=%0h, expected 1 0 0 09",
               halted, busy, if_valid, mem_add);
    end
`ifdef FETCH_PERF_CNT_EN
    tests_run++;
    if (fetch_cnt !== 16'd10 || stall_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL run_counters: got fetch=%0d stall=%0d, expected 10 0", fetch_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_stall;
    int n = 0;
    if_ready = 1'b1;
    push_range(0, 10);
    pulse_start();
    while (!(if_valid && if_pc == 8'h02) && n < 50) begin tick(); n++; end
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (if_valid !== 1'b1 || if_pc !== 8'h02 || if_instr !== prog[2] || mem_add !== 8'h03) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got v=%0b pc=%0h instr=%0h add=%0h, expected 1 02 %0h 03",
                 i, if_valid, if_pc, if_instr, mem_add, prog[2]);
      end
      tick();
    end
    if_ready = 1'b1;
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 8'h03) begin
      tests_failed++;
      $display("FAIL stall_resume: got v=%0b pc=%0h, expected 1 03", if_valid, if_pc);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    tests_run++;
    if (exp_q.size() != 0 || halted !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_drain: got %0d left, halted=%0b, expected 0 1", exp_q.size(), halted);
    end
  endtask

  task automatic test_restart;
    int n = 0;
`ifdef FETCH_PERF_CNT_EN
    tests_run++;
    if (fetch_cnt !== 16'd10 || stall_cnt !== 16'd3) begin
      tests_failed++;
      $display("FAIL stall_counters: got fetch=%0d stall=%0d, expected 10 3", fetch_cnt, stall_cnt);
    end
`endif
    if_ready = 1'b1;
    pulse_start();
    tests_run++;
    if (busy !== 1'b1 || halted !== 1'b0 || if_valid !== 1'b0 || mem_add !== 8'h00) begin
      tests_failed++;
      $display("FAIL restart_state: got b=%0b h=%0b v=%0b add=%0h, expected 1 0 0 00",
               busy, halted, if_valid, mem_add);
    end
`ifdef FETCH_PERF_CNT_EN
    tests_run++;
    if (fetch_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL restart_counters: got fetch=%0d stall=%0d, expected 0 0", fetch_cnt, stall_cnt);
    end
`endif
    push_range(0, 3);
    while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL restart_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_redirect;
    int n = 0;
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 8'h03) begin
      tests_failed++;
      $display("FAIL redirect_pre: got v=%0b pc=%0h, expected 1 03", if_valid, if_pc);
    end
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h05;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (if_valid !== 1'b0 || mem_add !== 8'h05) begin
      tests_failed++;
      $display("FAIL redirect_flush: got v=%0b add=%0h, expected 0 05", if_valid, mem_add);
    end
    push_range(5, 5);
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 8'h05 || if_instr !== prog[5]) begin
      tests_failed++;
      $display("FAIL redirect_target: got v=%0b pc=%0h instr=%0h, expected 1 05 %0h",
               if_valid, if_pc, if_instr, prog[5]);
    end
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    tests_run++;
    if (exp_q.size() != 0 || halted !== 1'b1) begin
      tests_failed++;
      $display("FAIL redirect_drain: got %0d left, halted=%0b, expected 0 1", exp_q.size(), halted);
    end
  endtask

  task automatic test_wrap;
    int n = 0;
    if_ready = 1'b1;
    pulse_start();
    redirect_valid = 1'b1;
    redirect_pc = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (mem_add !== 8'hFF || if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_redirect: got add=%0h v=%0b, expected ff 0", mem_add, if_valid);
    end
    push_range(255, 11);
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    tests_run++;
    if (exp_q.size() != 0 || halted !== 1'b1 || mem_add !== 8'h09) begin
      tests_failed++;
      $display("FAIL wrap_drain: got %0d left, halted=%0b add=%0h, expected 0 1 09",
               exp_q.size(), halted, mem_add);
    end
  endtask

  task automatic test_reset_halt_pend;
    int n = 0;
    if_ready = 1'b1;
    push_range(0, 9);
    pulse_start();
    while (!(if_valid && if_pc == 8'h09) && n < 50) begin tick(); n++; end
    if_ready = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || halted !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL halt_pend_state: got b=%0b h=%0b left=%0d, expected 1 0 0",
               busy, halted, exp_q.size());
    end
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({if_valid, busy, halted} !== 3'b000 || mem_add !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%0b b=%0b h=%0b add=%0h, expected 0 0 0 00",
               if_valid, busy, halted, mem_add);
    end
    tick();
    rst_n = 1'b1;
    if_ready = 1'b1;
    push_range(0, 10);
    pulse_start();
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    tests_run++;
    if (exp_q.size() != 0 || halted !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_restart: got %0d left, halted=%0b, expected 0 1", exp_q.size(), halted);
    end
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom();
      prog[i] = {w[31:7], 7'h13};
    end
    prog[0] = 32'h00500113;  // addi x2, x0, 5
    prog[1] = 32'h002101B3;  // add  x3, x2, x2
    prog[2] = 32'h40218233;  // sub  x4, x3, x2
    prog[3] = 32'h0021F2B3;  // and  x5, x3, x2
    prog[4] = 32'h0021E333;  // or   x6, x3, x2
    prog[5] = 32'h0021C3B3;  // xor  x7, x3, x2
    prog[6] = 32'h00310133;  // add  x2, x2, x3
    prog[7] = 32'h00310433;  // add  x8, x2, x3
    prog[8] = 32'h003104B3;  // add  x9, x2, x3
    prog[9] = 32'h0000007F;  // halt

    test_reset();
    test_run_to_halt();
    test_stall();
    test_restart();
    test_redirect();
    test_wrap();
    test_reset_halt_pend();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
